mem_wb_arbiter: RTL and testbench

- Two-master Wishbone arbiter that shares the single-port SoC memory Wishbone slave (mem_wb) between the management core and a user-side or DMA requester.
- Grants one master per transaction using round-robin priority and muxes address, data, select and write-enable onto the slave.
- Routes the slave's ack and read data back to the granted master only.
- Sits between the bus interconnect and the memory block; no address decoding.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_watchdog.sv | 37 +++
 rtl/mem_wb_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_wb_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the mem_wb two-master arbiter.
package mem_arb_pkg;

  localparam int ADR_W       = 32;
  localparam int DAT_W       = 32;
  localparam int SEL_W       = 4;
  localparam int NUM_MASTERS = 2;
  localparam int MIDX_W      = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic logic [NUM_MASTERS-1:0] onehot(
    input logic [MIDX_W-1:0] idx
  );
    return NUM_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// BUSY watchdog: counts ack-less BUSY cycles and flags the last one.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero in IDLE so every BUSY entry starts from a clear count
  always_comb begin
    cnt_d = cnt_q;
    if (!busy_i) begin
      cnt_d = '0;
    end else if (!ack_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = busy_i &&
    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of mem_wb.
// Define ARB_TIMEOUT_EN to build the BUSY watchdog (err abort).
module mem_wb_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RESET_PRIO     = 0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic             s_ack_i,
  input  logic [DAT_W-1:0] s_dat_i,
  output logic [NUM_MASTERS-1:0] gnt_o
);

  if (TIMEOUT_CYCLES < 4 || RESET_PRIO < 0 ||
      RESET_PRIO > 1) begin : g_bad_cfg
    $error("mem_wb_arbiter: bad TIMEOUT_CYCLES/RESET_PRIO");
  end

  arb_state_e        state_q, state_d;
  logic [MIDX_W-1:0] gidx_q, gidx_d;
  logic [MIDX_W-1:0] prio_q, prio_d;
  logic              req0, req1;
  logic              cyc_g, stb_g;
  logic              tmo;

  assign req0  = m0_cyc_i & m0_stb_i;
  assign req1  = m1_cyc_i & m1_stb_i;
  assign cyc_g = gidx_q ? m1_cyc_i : m0_cyc_i;
  assign stb_g = gidx_q ? m1_stb_i : m0_stb_i;

`ifdef ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .busy_i   (state_q == BUSY),
    .ack_i    (s_ack_i),
    .timeout_o(tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    prio_d   = prio_q;
    gnt_o    = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = BUSY;
          gidx_d  = (req0 & req1) ? prio_q : req1;
        end
      end
      BUSY: begin
        gnt_o    = onehot(gidx_q);
        s_adr_o  = gidx_q ? m1_adr_i : m0_adr_i;
        s_dat_o  = gidx_q ? m1_dat_i : m0_dat_i;
        s_sel_o  = gidx_q ? m1_sel_i : m0_sel_i;
        s_we_o   = gidx_q ? m1_we_i  : m0_we_i;
        s_cyc_o  = cyc_g & stb_g;
        s_stb_o  = cyc_g & stb_g;
        m0_ack_o = s_ack_i & gnt_o[0];
        m1_ack_o = s_ack_i & gnt_o[1];
        m0_dat_o = gnt_o[0] ? s_dat_i : '0;
        m1_dat_o = gnt_o[1] ? s_dat_i : '0;
        // Ack wins over abort and timeout in the same cycle
        if (s_ack_i) begin
          state_d = IDLE;
          prio_d  = ~gidx_q;
        end else if (!cyc_g) begin
          state_d = IDLE;
        end else if (tmo) begin
          state_d  = IDLE;
          prio_d   = ~gidx_q;
          m0_err_o = gnt_o[0];
          m1_err_o = gnt_o[1];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      prio_q  <= MIDX_W'(RESET_PRIO);
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_arbiter.sv
// Bench for mem_wb_arbiter: directed scenarios plus random traffic
// checked each cycle against a round-robin reference model.
module tb_mem_wb_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 16;
`endif
  localparam int RP = 0;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i;
  logic        m1_we_i, m1_cyc_i, m1_stb_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  gnt_o;

  always #5 clk = ~clk;

  mem_wb_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .RESET_PRIO    (RP)
  ) dut (
    .wb_clk_i(clk),      .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_sel_i(m0_sel_i), .m0_we_i (m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_sel_i(m1_sel_i), .m1_we_i (m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_adr_o (s_adr_o),  .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),  .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),  .s_stb_o (s_stb_o),
    .s_ack_i (s_ack_i),  .s_dat_i (s_dat_i),
    .gnt_o   (gnt_o)
  );

  wire [1:0]  ack_w = {m1_ack_o, m0_ack_o};
  wire [1:0]  err_w = {m1_err_o, m0_err_o};
  wire [31:0] dat_w [2];
  assign dat_w[0] = m0_dat_o;
  assign dat_w[1] = m1_dat_o;

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] nw,
    input logic [3:0] sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Slave stub: acks after slave_lat stalled cycles, never twice in a row
  logic [31:0] smem [16] = '{default: 32'h0};
  logic        stub_ack = 1'b0;
  logic [31:0] stub_rdat = 32'h0;
  int          wcnt = 0;
  int          slave_lat = 0;
  logic        slave_mute = 1'b0;
  logic        force_ack = 1'b0;

  assign s_ack_i = stub_ack | force_ack;
  assign s_dat_i = stub_rdat;

  always @(posedge clk) begin
    stub_ack <= 1'b0;
    if (s_cyc_o && s_stb_o && !stub_ack && !slave_mute) begin
      if (wcnt >= slave_lat) begin
        stub_ack <= 1'b1;
        wcnt     <= 0;
        if (s_we_o)
          smem[s_adr_o[5:2]] <=
            merge(smem[s_adr_o[5:2]], s_dat_o, s_sel_o);
        else
          stub_rdat <= smem[s_adr_o[5:2]];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Master drivers and reference model state
  logic        act [2];
  logic        auto_rq [2];
  logic        done [2];
  logic [31:0] adr_v [2], dat_v [2];
  logic [3:0]  sel_v [2];
  logic        we_v [2];
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  logic [31:0] last_rd [2];
  int          acks [2], errs [2];
  bit          mb;
  int          mo, mp, bcnt;
  int          gq [$];
  logic        gap, last_stb;
  int          pass_cnt = 0, total_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive();
    m0_cyc_i = act[0]; m0_stb_i = act[0];
    m0_adr_i = adr_v[0]; m0_dat_i = dat_v[0];
    m0_sel_i = sel_v[0]; m0_we_i = we_v[0];
    m1_cyc_i = act[1]; m1_stb_i = act[1];
    m1_adr_i = adr_v[1]; m1_dat_i = dat_v[1];
    m1_sel_i = sel_v[1]; m1_we_i = we_v[1];
  endtask

  task automatic new_txn(input int n, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic w);
    adr_v[n] = a; dat_v[n] = d; sel_v[n] = s; we_v[n] = w;
    act[n] = 1'b1;
    drive();
  endtask

  task automatic rand_txn(input int n);
    new_txn(n, 32'($urandom_range(0, 15)) << 2, $urandom,
            4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic model_reset();
    mb = 1'b0; mp = RP; bcnt = 0; gap = 1'b0;
  endtask

  // One bus cycle: check at negedge, advance model, act after posedge
  task automatic tick();
    logic [1:0]  eg;
    logic        ea, ee, own_cyc;
    logic [31:0] ed;
    @(negedge clk);
    own_cyc = mb && act[mo];
    eg = mb ? 2'(1 << mo) : 2'b00;
    chk("gnt", 32'(gnt_o), 32'(eg));
    chk("s_stb", 32'(s_stb_o), 32'(own_cyc));
    chk("s_cyc", 32'(s_cyc_o), 32'(own_cyc));
    if (mb) begin
      chk("s_adr", s_adr_o, adr_v[mo]);
      chk("s_dat", s_dat_o, dat_v[mo]);
      chk("s_sel", 32'(s_sel_o), 32'(sel_v[mo]));
      chk("s_we", 32'(s_we_o), 32'(we_v[mo]));
    end
    if (wb_rst_i) begin
      chk("rst_s_adr", s_adr_o, 32'h0);
      chk("rst_s_sel", 32'(s_sel_o), 32'h0);
      chk("rst_s_we", 32'(s_we_o), 32'h0);
    end
    if (gap) chk("idle_gap", 32'(s_stb_o), 32'h0);
    for (int n = 0; n < 2; n++) begin
      ea = mb && mo == n && s_ack_i;
      ee = 1'b0;
`ifdef ARB_TIMEOUT_EN
      ee = mb && mo == n && !s_ack_i && act[n] && bcnt == TO;
`endif
      ed = (mb && mo == n) ? s_dat_i : 32'h0;
      chk($sformatf("ack%0d", n), 32'(ack_w[n]), 32'(ea));
      chk($sformatf("err%0d", n), 32'(err_w[n]), 32'(ee));
      chk($sformatf("dat%0d", n), dat_w[n], ed);
      if (ea && !we_v[n]) begin
        chk($sformatf("rdata%0d", n), dat_w[n],
            ref_mem[adr_v[n][5:2]]);
        last_rd[n] = dat_w[n];
      end
      if (ack_w[n]) acks[n]++;
      if (err_w[n]) errs[n]++;
    end
    last_stb = s_stb_o;
    gap = mb && s_ack_i;
    if (wb_rst_i) begin
      model_reset();
    end else if (!mb) begin
      if (act[0] || act[1]) begin
        mb = 1'b1;
        mo = (act[0] && act[1]) ? mp : (act[0] ? 0 : 1);
        bcnt = 1;
        gq.push_back(mo);
      end
    end else if (s_ack_i) begin
      if (we_v[mo])
        ref_mem[adr_v[mo][5:2]] =
          merge(ref_mem[adr_v[mo][5:2]], dat_v[mo], sel_v[mo]);
      done[mo] = 1'b1;
      mb = 1'b0;
      mp = 1 - mo;
    end else if (!act[mo]) begin
      mb = 1'b0;
`ifdef ARB_TIMEOUT_EN
    end else if (bcnt == TO) begin
      done[mo] = 1'b1;
      mb = 1'b0;
      mp = 1 - mo;
`endif
    end else begin
      bcnt++;
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (done[n]) begin
        done[n] = 1'b0;
        act[n] = 1'b0;
        if (auto_rq[n]) rand_txn(n);
      end
    end
    drive();
  endtask

  task automatic wait_done(input int n, input int budget,
                           input string tag);
    int k;
    k = 0;
    while (act[n] && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(act[n]), 32'h0);
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      act[n] = 1'b0; auto_rq[n] = 1'b0; done[n] = 1'b0;
    end
    drive();
    model_reset();
    gq.delete();
    tick();
    tick();
    wb_rst_i = 1'b0;
  endtask

  initial begin
    int a0;
    for (int n = 0; n < 2; n++) begin
      act[n] = 1'b0; auto_rq[n] = 1'b0; done[n] = 1'b0;
      adr_v[n] = 32'h0; dat_v[n] = 32'h0; sel_v[n] = 4'h0;
      we_v[n] = 1'b0; acks[n] = 0; errs[n] = 0;
      last_rd[n] = 32'h0;
    end
    wb_rst_i = 1'b1;
    drive();
    model_reset();
    tick();
    tick();
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_s_stb", 32'(s_stb_o), 32'h0);
    chk("rst_m0_ack", 32'(m0_ack_o), 32'h0);
    chk("rst_m1_err", 32'(m1_err_o), 32'h0);
    chk("rst_m0_dat", m0_dat_o, 32'h0);
    wb_rst_i = 1'b0;

    // Single write, then read back
    a0 = acks[0];
    new_txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    tick();
    chk("wr_req_cycle_stb", 32'(last_stb), 32'h0);
    tick();
    chk("wr_stb_after_1", 32'(last_stb), 32'h1);
    chk("wr_gnt", 32'(gnt_o), 32'h1);
    wait_done(0, 20, "wr_done");
    chk("wr_ack_pulses", 32'(acks[0] - a0), 32'h1);
    new_txn(0, 32'h10, 32'h0, 4'hF, 1'b0);
    wait_done(0, 20, "rd_done");
    chk("rd_value", last_rd[0], 32'hDEADBEEF);

    // Contention from reset and fairness under continuous requests
    do_reset();
    auto_rq[0] = 1'b1;
    auto_rq[1] = 1'b1;
    rand_txn(0);
    rand_txn(1);
    for (int k = 0; k < 100 && gq.size() < 6; k++) tick();
    auto_rq[0] = 1'b0;
    auto_rq[1] = 1'b0;
    wait_done(0, 20, "fair_drain0");
    wait_done(1, 20, "fair_drain1");
    chk("fair_count", 32'(gq.size() >= 6), 32'h1);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      chk($sformatf("fair_gnt%0d", i), 32'(gq[i]), 32'(i % 2));

    // Abort: m1 drops cyc, keeps its turn
    do_reset();
    new_txn(0, 32'h4, 32'h11223344, 4'h3, 1'b1);
    wait_done(0, 20, "ab_m0_done");
    slave_mute = 1'b1;
    a0 = acks[1];
    new_txn(1, 32'h8, 32'h0, 4'hF, 1'b0);
    tick();
    tick();
    act[1] = 1'b0;
    drive();
    tick();
    tick();
    chk("ab_gnt_idle", 32'(gnt_o), 32'h0);
    chk("ab_no_ack", 32'(acks[1] - a0), 32'h0);
    slave_mute = 1'b0;
    new_txn(0, 32'hC, 32'h0, 4'hF, 1'b0);
    new_txn(1, 32'h8, 32'h0, 4'hF, 1'b0);
    tick();
    chk("ab_prio_kept", 32'(gq[gq.size()-1]), 32'h1);
    wait_done(1, 20, "ab_m1_done");
    wait_done(0, 20, "ab_m0_done2");

    // Reset while a read is in flight
    do_reset();
    slave_mute = 1'b1;
    new_txn(0, 32'h10, 32'h0, 4'hF, 1'b0);
    tick();
    tick();
    wb_rst_i = 1'b1;
    act[0] = 1'b0;
    drive();
    model_reset();
    #1;
    chk("mid_rst_cyc", 32'(s_cyc_o), 32'h0);
    chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
    force_ack = 1'b1;
    #1;
    chk("mid_rst_ack0", 32'(m0_ack_o), 32'h0);
    chk("mid_rst_ack1", 32'(m1_ack_o), 32'h0);
    tick();
    wb_rst_i = 1'b0;
    tick();
    force_ack = 1'b0;
    slave_mute = 1'b0;
    new_txn(1, 32'h10, 32'h0, 4'hF, 1'b0);
    wait_done(1, 20, "post_rst_done");
    chk("post_rst_gnt", 32'(gq[gq.size()-1]), 32'h1);
    chk("post_rst_rd", last_rd[1], ref_mem[4]);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: slave never acks m0, pending m1 goes next
    do_reset();
    slave_mute = 1'b1;
    a0 = errs[0];
    new_txn(0, 32'h20, 32'h0, 4'hF, 1'b0);
    new_txn(1, 32'h24, 32'h0, 4'hF, 1'b0);
    wait_done(0, 30, "to_m0_err");
    slave_mute = 1'b0;
    chk("to_err_pulses", 32'(errs[0] - a0), 32'h1);
    wait_done(1, 20, "to_m1_done");
    chk("to_next_gnt", 32'(gq.size() >= 2 ? gq[1] : -1), 32'h1);
`endif

    // Random traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int n = 0; n < 2; n++)
        if (!act[n] && $urandom_range(0, 2) == 0) rand_txn(n);
      slave_lat = $urandom_range(0, 2);
      tick();
    end
    wait_done(0, 30, "rnd_drain0");
    wait_done(1, 30, "rnd_drain1");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
